// File: rtl/xtea_pkg.sv
// Shared constants, register offsets and types for the IOBUS XTEA coprocessor.
package xtea_pkg;

  localparam logic [31:0] DELTA        = 32'h9E3779B9;
  localparam logic [31:0] SUM_DEC_INIT = 32'hC6EF3720;

  localparam logic [4:0] OFF_KEY0   = 5'h00;
  localparam logic [4:0] OFF_KEY1   = 5'h04;
  localparam logic [4:0] OFF_KEY2   = 5'h08;
  localparam logic [4:0] OFF_KEY3   = 5'h0C;
  localparam logic [4:0] OFF_DATA0  = 5'h10;
  localparam logic [4:0] OFF_DATA1  = 5'h14;
  localparam logic [4:0] OFF_CTRL   = 5'h18;
  localparam logic [4:0] OFF_STATUS = 5'h1C;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} xtea_state_t;

  typedef logic [31:0] key_t[4];

  function automatic logic [31:0] xtea_mix(input logic [31:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

endpackage

// File: rtl/xtea_round.sv
// One full XTEA cycle (both halves) in either direction; purely combinational.
module xtea_round
  import xtea_pkg::*;
(
  input  logic [31:0] v0,
  input  logic [31:0] v1,
  input  logic [31:0] sum,
  input  key_t        key,
  input  logic        mode,
  output logic [31:0] v0_nxt,
  output logic [31:0] v1_nxt,
  output logic [31:0] sum_nxt
);

  always_comb begin
    v0_nxt  = v0;
    v1_nxt  = v1;
    sum_nxt = sum;
    if (!mode) begin
      v0_nxt  = v0 + (xtea_mix(v1) ^ (sum + key[sum[1:0]]));
      sum_nxt = sum + DELTA;
      v1_nxt  = v1 + (xtea_mix(v0_nxt) ^ (sum_nxt + key[sum_nxt[12:11]]));
    end else begin
      // Decrypt undoes the encrypt steps in reverse order.
      v1_nxt  = v1 - (xtea_mix(v0) ^ (sum + key[sum[12:11]]));
      sum_nxt = sum - DELTA;
      v0_nxt  = v0 - (xtea_mix(v1_nxt) ^ (sum_nxt + key[sum_nxt[1:0]]));
    end
  end

endmodule

// File: rtl/iobus_xtea_engine.sv
// Memory-mapped XTEA coprocessor on the MCU IOBUS: key/data/ctrl registers,
// a one-cycle-per-round FSM and a combinational read port with hit flag.
module iobus_xtea_engine
  import xtea_pkg::*;
#(
  parameter logic [31:0] BASE_AD = 32'h11800000,
  parameter int          ROUNDS  = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        RD_HIT,
  output logic        DONE_IRQ
);

  localparam int CNT_W = $clog2(ROUNDS + 1);

  xtea_state_t      state;
  key_t             key;
  logic [31:0]      data0, data1, v0, v1, sum, result0, result1;
  logic [31:0]      v0_nxt, v1_nxt, sum_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mode, done, busy;
  logic [31:0]      off;
  logic             wr_hit, cfg_wr;

  assign off    = IOBUS_ADDR - BASE_AD;
  assign RD_HIT = (off[31:5] == '0) && (off[1:0] == 2'b00);
  assign busy   = (state == RUN);
  assign wr_hit = IOBUS_WR && RD_HIT;
  // Key, data and control are frozen while a run is in progress.
  assign cfg_wr = wr_hit && !busy;

  xtea_round u_round (
    .v0      (v0),
    .v1      (v1),
    .sum     (sum),
    .key     (key),
    .mode    (mode),
    .v0_nxt  (v0_nxt),
    .v1_nxt  (v1_nxt),
    .sum_nxt (sum_nxt)
  );

  always_comb begin
    RD_DATA = '0;
    if (RD_HIT) begin
      case (off[4:0])
        OFF_DATA0:  RD_DATA = result0;
        OFF_DATA1:  RD_DATA = result1;
        OFF_STATUS: RD_DATA = {30'b0, done, busy};
        default:    RD_DATA = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      key      <= '{default: '0};
      data0    <= '0;
      data1    <= '0;
      v0       <= '0;
      v1       <= '0;
      sum      <= '0;
      result0  <= '0;
      result1  <= '0;
      cnt      <= '0;
      mode     <= 1'b0;
      done     <= 1'b0;
      DONE_IRQ <= 1'b0;
    end else begin
      DONE_IRQ <= 1'b0;
      if (cfg_wr) begin
        case (off[4:0])
          OFF_KEY0, OFF_KEY1, OFF_KEY2, OFF_KEY3: key[off[3:2]] <= IOBUS_OUT;
          OFF_DATA0: data0 <= IOBUS_OUT;
          OFF_DATA1: data1 <= IOBUS_OUT;
          default: ;
        endcase
      end
      if (wr_hit && off[4:0] == OFF_STATUS && IOBUS_OUT[1]) done <= 1'b0;
      // FINISH below is later in the block, so completion beats a same-edge clear.
      case (state)
        IDLE: begin
          if (cfg_wr && off[4:0] == OFF_CTRL && IOBUS_OUT[0]) begin
            v0    <= data0;
            v1    <= data1;
            sum   <= IOBUS_OUT[1] ? SUM_DEC_INIT : 32'h0;
            cnt   <= '0;
            done  <= 1'b0;
            mode  <= IOBUS_OUT[1];
            state <= RUN;
          end
        end
        RUN: begin
          v0  <= v0_nxt;
          v1  <= v1_nxt;
          sum <= sum_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ROUNDS - 1)) state <= FINISH;
        end
        FINISH: begin
          result0  <= v0;
          result1  <= v1;
          done     <= 1'b1;
          DONE_IRQ <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_xtea_engine.sv
// Scoreboarded bench for iobus_xtea_engine: a reference XTEA model queues the
// expected block at each START, and completions pop and compare it.
module tb_iobus_xtea_engine;

  localparam logic [31:0] BASE   = 32'h11800000;
  localparam logic [31:0] A_KEY0 = BASE + 32'h00;
  localparam logic [31:0] A_DAT0 = BASE + 32'h10;
  localparam logic [31:0] A_DAT1 = BASE + 32'h14;
  localparam logic [31:0] A_CTRL = BASE + 32'h18;
  localparam logic [31:0] A_STAT = BASE + 32'h1C;
  localparam logic [31:0] K_DELTA = 32'h9E3779B9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] iobus_addr = '0;
  logic [31:0] iobus_out = '0;
  logic        iobus_wr = 1'b0;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic        done_irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] key_m[4];
  logic [31:0] d0_m, d1_m;
  logic [63:0] sb_q[$];
  logic [31:0] rv;
  logic        rh;

  iobus_xtea_engine dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .IOBUS_ADDR (iobus_addr),
    .IOBUS_OUT  (iobus_out),
    .IOBUS_WR   (iobus_wr),
    .RD_DATA    (rd_data),
    .RD_HIT     (rd_hit),
    .DONE_IRQ   (done_irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xtea_model(input logic [31:0] a, input logic [31:0] b, input bit dec);
    logic [31:0] s;
    if (!dec) begin
      s = 32'h0;
      repeat (32) begin
        a = a + ((((b << 4) ^ (b >> 5)) + b) ^ (s + key_m[s[1:0]]));
        s = s + K_DELTA;
        b = b + ((((a << 4) ^ (a >> 5)) + a) ^ (s + key_m[s[12:11]]));
      end
    end else begin
      s = K_DELTA * 32'd32;
      repeat (32) begin
        b = b - ((((a << 4) ^ (a >> 5)) + a) ^ (s + key_m[s[12:11]]));
        s = s - K_DELTA;
        a = a - ((((b << 4) ^ (b >> 5)) + b) ^ (s + key_m[s[1:0]]));
      end
    end
    return {a, b};
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    @(negedge clk);
    iobus_wr   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    iobus_wr   = 1'b0;
    iobus_addr = a;
    #1;
    d = rd_data;
    h = rd_hit;
  endtask

  task automatic set_key(input logic [31:0] k0, k1, k2, k3);
    key_m[0] = k0; key_m[1] = k1; key_m[2] = k2; key_m[3] = k3;
    for (int i = 0; i < 4; i++) bus_write(A_KEY0 + 32'(4 * i), key_m[i]);
  endtask

  task automatic set_data(input logic [31:0] a, input logic [31:0] b);
    d0_m = a; d1_m = b;
    bus_write(A_DAT0, a);
    bus_write(A_DAT1, b);
  endtask

  task automatic start_op(input bit dec);
    sb_q.push_back(xtea_model(d0_m, d1_m, dec));
    bus_write(A_CTRL, {30'b0, dec, 1'b1});
  endtask

  // Called right after start_op; cycle k is the k-th negedge after the START edge.
  task automatic wait_done(input bit disturb, input bit clr_edge);
    int done_at = -1;
    int busy_cnt = 0;
    logic [31:0] r0, r1;
    logic [63:0] exp;
    for (int k = 0; k < 100; k++) begin
      if (done_irq) begin
        done_at = k;
        break;
      end
      bus_read(A_STAT, rv, rh);
      if (rv[0]) busy_cnt++;
      if (disturb && k == 4) begin iobus_addr = A_DAT0; iobus_out = 32'hFFFFFFFF; iobus_wr = 1'b1; end
      if (disturb && k == 5) begin iobus_addr = A_KEY0; iobus_out = 32'h1; iobus_wr = 1'b1; end
      if (disturb && k == 6) begin iobus_addr = A_CTRL; iobus_out = 32'h1; iobus_wr = 1'b1; end
      if (clr_edge && k == 32) begin iobus_addr = A_STAT; iobus_out = 32'h2; iobus_wr = 1'b1; end
      @(negedge clk);
    end
    iobus_wr = 1'b0;
    check_eq("done_cycle", 32'(done_at), 32'd33);
    check_eq("busy_cycles", 32'(busy_cnt), 32'd32);
    bus_read(A_STAT, rv, rh);
    check_eq("status_done", rv, 32'h2);
    bus_read(A_DAT0, r0, rh);
    bus_read(A_DAT1, r1, rh);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check_eq("result0", r0, exp[63:32]);
      check_eq("result1", r1, exp[31:0]);
    end else begin
      check_eq("sb_empty", 32'(sb_q.size()), 32'd1);
    end
    @(negedge clk);
    check_eq("irq_one_cycle", {31'b0, done_irq}, 32'h0);
  endtask

  initial begin
    key_m = '{default: '0};
    d0_m = '0; d1_m = '0;
    repeat (3) @(negedge clk);
    check_eq("irq_in_reset", {31'b0, done_irq}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(A_STAT, rv, rh); check_eq("rst_status", rv, 32'h0);
    bus_read(A_DAT0, rv, rh); check_eq("rst_result0", rv, 32'h0);
    bus_read(A_DAT1, rv, rh); check_eq("rst_result1", rv, 32'h0);
    check_eq("rst_irq", {31'b0, done_irq}, 32'h0);

    // Zero key / zero block known answer.
    set_key(32'h0, 32'h0, 32'h0, 32'h0);
    set_data(32'h0, 32'h0);
    start_op(1'b0);
    wait_done(1'b0, 1'b0);
    bus_read(A_DAT0, rv, rh); check_eq("kat0_r0", rv, 32'hDEE9D4D8);
    bus_read(A_DAT1, rv, rh); check_eq("kat0_r1", rv, 32'hF7131ED9);

    // Round trip with the standard test key.
    set_key(32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);
    set_data(32'h41424344, 32'h45464748);
    start_op(1'b0);
    wait_done(1'b0, 1'b0);
    bus_read(A_DAT0, rv, rh); check_eq("kat1_enc_r0", rv, 32'h497DF3D0);
    bus_read(A_DAT1, rv, rh); check_eq("kat1_enc_r1", rv, 32'h72612CB5);
    set_data(32'h497DF3D0, 32'h72612CB5);
    start_op(1'b1);
    wait_done(1'b0, 1'b0);
    bus_read(A_DAT0, rv, rh); check_eq("kat1_dec_r0", rv, 32'h41424344);
    bus_read(A_DAT1, rv, rh); check_eq("kat1_dec_r1", rv, 32'h45464748);

    // DONE clear and no-op CTRL write.
    bus_write(A_STAT, 32'h2);
    bus_read(A_STAT, rv, rh); check_eq("status_cleared", rv, 32'h0);
    bus_write(A_CTRL, 32'h2);
    @(negedge clk);
    bus_read(A_STAT, rv, rh); check_eq("ctrl_nostart", rv, 32'h0);

    // Writes during RUN are ignored; then a clear racing the completion edge.
    set_data(32'h01234567, 32'h89ABCDEF);
    start_op(1'b0);
    wait_done(1'b1, 1'b0);
    set_data(32'hCAFEF00D, 32'h12345678);
    start_op(1'b1);
    wait_done(1'b0, 1'b1);

    // Address decode.
    bus_read(BASE + 32'h20, rv, rh);
    check_eq("dec_past_hit", {31'b0, rh}, 32'h0); check_eq("dec_past_data", rv, 32'h0);
    bus_read(BASE + 32'h02, rv, rh);
    check_eq("dec_unal_hit", {31'b0, rh}, 32'h0); check_eq("dec_unal_data", rv, 32'h0);
    bus_read(32'h11000000, rv, rh);
    check_eq("dec_other_hit", {31'b0, rh}, 32'h0); check_eq("dec_other_data", rv, 32'h0);
    bus_read(A_KEY0, rv, rh);
    check_eq("dec_key_hit", {31'b0, rh}, 32'h1); check_eq("dec_key_data", rv, 32'h0);

    // Reset in the middle of a run aborts it.
    start_op(1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    bus_read(A_STAT, rv, rh); check_eq("midrst_status", rv, 32'h0);
    bus_read(A_DAT0, rv, rh); check_eq("midrst_result0", rv, 32'h0);
    void'(sb_q.pop_front());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check_eq("midrst_no_irq", {31'b0, done_irq}, 32'h0);
    end
    bus_read(A_STAT, rv, rh); check_eq("midrst_status_after", rv, 32'h0);
    bus_read(A_DAT1, rv, rh); check_eq("midrst_result1_after", rv, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
